vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, expected clocks per line.
REQ-002 SHALL have parameter V_TOTAL, default 525, expected lines per frame.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames required to assert lock.
REQ-004 SHALL have port clk_i  in  1  pixel clock, all logic on rising edge.
REQ-005 SHALL have port rst_ni  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port hsync_n_i  in  1  active-low horizontal sync, synchronous to clk_i.
REQ-007 SHALL have port vsync_n_i  in  1  active-low vertical sync, synchronous to clk_i.
REQ-008 SHALL have port blank_n_i  in  1  1 = visible pixel this clock.
REQ-009 SHALL have port x_o  out  10  visible pixel column of current output pixel.
REQ-010 SHALL have port y_o  out  10  visible line index of current output pixel.
REQ-011 SHALL have port pixel_valid_o  out  1  x_o/y_o refer to a visible pixel.
REQ-012 SHALL have port eol_o  out  1  one-cycle strobe after the last visible pixel of a line.
REQ-013 SHALL have port sof_o  out  1  one-cycle strobe coincident with pixel (0,0).
REQ-014 SHALL have port h_total_o  out  11  last measured line length in clocks.
REQ-015 SHALL have port v_total_o  out  10  last measured frame length in lines.
REQ-016 SHALL have port locked_o  out  1  timing matches H_TOTAL/V_TOTAL.
REQ-017 SHALL have port error_o  out  1  sticky: lock was lost since reset.

Function
REQ-018 SHALL register all three inputs once (stage 1); all outputs are registered (stage 2); pixel_valid_o/x_o/y_o at cycle n+2 reflect inputs sampled at cycle n.
REQ-019 SHALL detect hsync falling edge (stage-1 hsync 1->0) as line start and vsync falling edge as frame start.
REQ-020 SHALL run an 11-bit clock counter h_cnt cleared to 0 on each line start, incrementing otherwise, saturating at 2047.
REQ-021 SHALL, on line start, load h_total_o <= h_cnt+1 (saturated 2047), only if a previous line start has been seen since reset.
REQ-022 SHALL run a 10-bit line counter v_cnt incremented on each line start, saturating at 1023; on frame start load v_total_o <= v_cnt (only if a previous frame start has been seen since reset), then clear v_cnt.
REQ-023 SHALL, on simultaneous line start and frame start, apply line-start processing first (v_cnt increment included in v_total_o).
REQ-024 SHALL clear x to 0 on line start and increment x each cycle with stage-1 blank_n=1; x wraps modulo 1024.
REQ-025 SHALL clear y to 0 on frame start and increment y at each line start that follows a line containing ≥1 visible pixel; y wraps modulo 1024.
REQ-026 SHALL assert eol_o one cycle on stage-1 blank_n 1->0 transition.
REQ-027 SHALL assert sof_o when pixel_valid_o=1, x_o=0, y_o=0.
REQ-028 SHALL implement lock FSM: UNLOCKED -> CHECK on first frame start with v_total_o==V_TOTAL and all lines of that frame h_total==H_TOTAL; CHECK counts good frames; CHECK -> LOCKED after LOCK_FRAMES consecutive good frames; any bad frame in CHECK -> UNLOCKED.
REQ-029 SHALL, in LOCKED, transition to UNLOCKED and set error_o on the first line start with measured h_total ≠ H_TOTAL, on frame start with v_total ≠ V_TOTAL, or when h_cnt reaches 2047 (sync lost), without waiting for frame end.
REQ-030 SHALL drive locked_o = 1 only in LOCKED; error_o clears only by reset.
REQ-031 SHALL keep x/y/pixel_valid/eol/sof functional regardless of lock state.

Reset
REQ-032 SHALL, on rst_ni low, asynchronously clear: x_o, y_o, h_total_o, v_total_o, counters, edge history = 0; pixel_valid_o, eol_o, sof_o, locked_o, error_o = 0; stage-1 syncs = 1 (inactive); FSM = UNLOCKED; "edge seen" flags cleared.
REQ-033 SHALL restart measurement after reset mid-frame; the first partial line/frame is never reported in h_total_o/v_total_o.

Verification
REQ-034 Standard 800x525 stream (hsync low clocks 656-751, vsync low lines 490-491, blank_n high x<640,y<480) -> h_total_o=800, v_total_o=525, locked_o=1 within 2 frames of first complete frame, error_o=0.
REQ-035 Locked stream, one line shortened to 799 clocks -> locked_o=0 at that line's end+2 cycles, error_o=1, h_total_o=799; relock after 2 good frames, error_o stays 1.
REQ-036 Locked, hsync held high -> locked_o falls when h_cnt hits 2047; h_total_o holds last value.
REQ-037 Visible pixel check: pixel_valid_o 2 cycles after blank_n_i, x_o 0..639, eol_o once per visible line (480 per frame), sof_o once per frame, y_o=479 on last visible line.
REQ-038 rst_ni pulsed mid-frame -> all outputs 0 immediately; no spurious h_total_o/v_total_o from partial line/frame; lock reacquired.
REQ-039 hsync and vsync falling edges in same cycle -> v_total_o includes that line, v_cnt=0 next frame.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, line/frame lengths and a timing-lock indication
// from a raw active-low VGA sync/blank stream.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        hsync_n_i,
    input  logic        vsync_n_i,
    input  logic        blank_n_i,
    output logic [9:0]  x_o,
    output logic [9:0]  y_o,
    output logic        pixel_valid_o,
    output logic        eol_o,
    output logic        sof_o,
    output logic [10:0] h_total_o,
    output logic [9:0]  v_total_o,
    output logic        locked_o,
    output logic        error_o
);
    localparam int          CNT_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [10:0] H_MAX = 11'h7FF;
    localparam logic [9:0]  V_MAX = 10'h3FF;

    typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;

    logic             hs_p1, vs_p1, vld_p1;
    logic             hs_p2, vs_p2, vld_p2;
    logic [10:0]      h_cnt;
    logic [9:0]       v_cnt, x_cnt, y_cnt;
    logic             had_vis, h_seen, v_seen, frame_bad;
    state_t           state, state_next;
    logic [CNT_W-1:0] good_cnt, good_cnt_next;
    logic             lose_lock;

    logic             line_start, frame_start, sync_lost, h_bad, frame_good;
    logic [10:0]      h_meas;
    logic [9:0]       v_line, x_cur, y_cur;

    // Stage 1: input registers plus one cycle of history for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
            vld_p1 <= 1'b0;
            hs_p2  <= 1'b0;
            vs_p2  <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            hs_p1  <= hsync_n_i;
            vs_p1  <= vsync_n_i;
            vld_p1 <= blank_n_i;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            vld_p2 <= vld_p1;
        end
    end

    always_comb begin
        line_start  = hs_p2 & ~hs_p1;
        frame_start = vs_p2 & ~vs_p1;
        sync_lost   = (h_cnt == H_MAX);
        h_meas      = sync_lost ? H_MAX : h_cnt + 11'd1;
        // A line start in the same cycle as a frame start belongs to the ending frame
        v_line      = (line_start && v_cnt != V_MAX) ? v_cnt + 10'd1 : v_cnt;
        h_bad       = line_start & h_seen & (h_meas != 11'(H_TOTAL));
        frame_good  = frame_start & v_seen & (v_line == 10'(V_TOTAL))
                    & ~frame_bad & ~h_bad & ~sync_lost;
        x_cur       = line_start ? 10'd0 : x_cnt;
        if (frame_start)
            y_cur = 10'd0;
        else if (line_start && had_vis)
            y_cur = y_cnt + 10'd1;
        else
            y_cur = y_cnt;
    end

    // Stage 2: counters, measurements and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            had_vis       <= 1'b0;
            h_seen        <= 1'b0;
            v_seen        <= 1'b0;
            frame_bad     <= 1'b0;
            h_total_o     <= '0;
            v_total_o     <= '0;
            x_o           <= '0;
            y_o           <= '0;
            pixel_valid_o <= 1'b0;
            eol_o         <= 1'b0;
            sof_o         <= 1'b0;
        end else begin
            h_cnt     <= line_start ? 11'd0 : (sync_lost ? h_cnt : h_cnt + 11'd1);
            v_cnt     <= frame_start ? 10'd0 : v_line;
            x_cnt     <= x_cur + {9'd0, vld_p1};
            y_cnt     <= y_cur;
            had_vis   <= (line_start ? 1'b0 : had_vis) | vld_p1;
            frame_bad <= frame_start ? 1'b0 : (frame_bad | h_bad | sync_lost);
            if (line_start) begin
                h_seen <= 1'b1;
                if (h_seen)
                    h_total_o <= h_meas;
            end
            if (frame_start) begin
                v_seen <= 1'b1;
                if (v_seen)
                    v_total_o <= v_line;
            end
            x_o           <= x_cur;
            y_o           <= y_cur;
            pixel_valid_o <= vld_p1;
            eol_o         <= vld_p2 & ~vld_p1;
            sof_o         <= vld_p1 & (x_cur == 10'd0) & (y_cur == 10'd0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
            error_o  <= 1'b0;
        end else begin
            state    <= state_next;
            good_cnt <= good_cnt_next;
            if (lose_lock)
                error_o <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        good_cnt_next = good_cnt;
        lose_lock     = 1'b0;
        case (state)
            UNLOCKED: begin
                if (frame_good) begin
                    good_cnt_next = CNT_W'(1);
                    state_next    = (LOCK_FRAMES <= 1) ? LOCKED : CHECK;
                end
            end
            CHECK: begin
                if (frame_start) begin
                    if (frame_good) begin
                        good_cnt_next = good_cnt + CNT_W'(1);
                        if (good_cnt_next >= CNT_W'(LOCK_FRAMES))
                            state_next = LOCKED;
                    end else begin
                        state_next = UNLOCKED;
                    end
                end
            end
            LOCKED: begin
                // Drop lock as soon as any line or frame is off, not at frame end
                if (h_bad || sync_lost || (frame_start && v_line != 10'(V_TOTAL))) begin
                    state_next = UNLOCKED;
                    lose_lock  = 1'b1;
                end
            end
            default: state_next = UNLOCKED;
        endcase
    end

    always_comb begin
        locked_o = (state == LOCKED);
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a scaled 40x20 timing (16x12 visible) so
// that many whole frames fit in a short run.
module tb_vga_sync_decoder;
    localparam int H   = 40;
    localparam int V   = 20;
    localparam int HV  = 16;
    localparam int HS0 = 24;
    localparam int HS1 = 31;
    localparam int VV  = 12;
    localparam int VS0 = 14;
    localparam int VS1 = 15;

    logic        clk, rst_ni, hsync_n, vsync_n, blank_n;
    logic [9:0]  x, y, v_total;
    logic [10:0] h_total;
    logic        pixel_valid, eol, sof, locked, error;

    vga_sync_decoder #(.H_TOTAL(H), .V_TOTAL(V), .LOCK_FRAMES(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .hsync_n_i(hsync_n), .vsync_n_i(vsync_n),
        .blank_n_i(blank_n), .x_o(x), .y_o(y), .pixel_valid_o(pixel_valid),
        .eol_o(eol), .sof_o(sof), .h_total_o(h_total), .v_total_o(v_total),
        .locked_o(locked), .error_o(error)
    );

    typedef struct { int x; int y; int t; } pix_t;
    typedef struct {
        int short_line; bit align;
        int h_total; int v_total; bit locked; bit error; int eols; int sofs;
    } row_t;

    pix_t q[$];
    row_t rows[11];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   eol_cnt = 0;
    int   sof_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pixel scoreboard: every visible pixel driven must come out 2 cycles later
    always @(negedge clk) begin
        if (rst_ni) begin
            if (pixel_valid) begin
                if (q.size() == 0) begin
                    check("pix_unexpected", 1, 0);
                end else begin
                    pix_t e;
                    e = q.pop_front();
                    check("pix_x", int'(x), e.x);
                    check("pix_y", int'(y), e.y);
                    check("pix_latency", cyc - e.t, 2);
                end
            end
            if (eol) eol_cnt++;
            if (sof) sof_cnt++;
        end
    end

    task automatic drive_raw(input bit h, input bit v, input bit b);
        @(negedge clk);
        hsync_n = h;
        vsync_n = v;
        blank_n = b;
    endtask

    task automatic drive_cycle(input int ln, input int c, input bit align);
        bit h, v, b;
        int pos;
        h = !(c >= HS0 && c <= HS1);
        if (align) begin
            pos = ln * H + c;
            v = !(pos >= VS0 * H + HS0 && pos < (VS1 + 1) * H + HS0);
        end else begin
            v = !(ln >= VS0 && ln <= VS1);
        end
        b = (c < HV) && (ln < VV);
        drive_raw(h, v, b);
        if (b) q.push_back('{x: c, y: ln, t: cyc});
    endtask

    task automatic drive_line(input int ln, input int len, input bit align);
        for (int c = 0; c < len; c++) drive_cycle(ln, c, align);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"}, int'(x), 0);
        check({tag, "_y"}, int'(y), 0);
        check({tag, "_pv"}, int'(pixel_valid), 0);
        check({tag, "_eol"}, int'(eol), 0);
        check({tag, "_sof"}, int'(sof), 0);
        check({tag, "_htot"}, int'(h_total), 0);
        check({tag, "_vtot"}, int'(v_total), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_error"}, int'(error), 0);
    endtask

    // Stream restarts at line 12: the partial line and frame must not be reported
    task automatic startup();
        drive_line(12, H, 1'b0);
        check("partial_htot", int'(h_total), 0);
        check("partial_vtot", int'(v_total), 0);
        for (int ln = 13; ln < V; ln++) drive_line(ln, H, 1'b0);
        check("start_htot", int'(h_total), H);
        check("start_vtot", int'(v_total), 0);
        check("start_locked", int'(locked), 0);
        check("start_error", int'(error), 0);
    endtask

    task automatic drive_frame(input int short_line, input bit align);
        for (int ln = 0; ln < V; ln++)
            drive_line(ln, (ln == short_line) ? H - 1 : H, align);
    endtask

    initial begin
        #4000000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int first_drop;
        rows[0]  = '{-1, 1'b0, H, V,     1'b0, 1'b0, VV, 1};
        rows[1]  = '{-1, 1'b0, H, V,     1'b1, 1'b0, VV, 1};
        rows[2]  = '{-1, 1'b0, H, V,     1'b1, 1'b0, VV, 1};
        rows[3]  = '{ 5, 1'b0, H, V,     1'b0, 1'b1, VV, 1};
        rows[4]  = '{-1, 1'b0, H, V,     1'b0, 1'b1, VV, 1};
        rows[5]  = '{-1, 1'b0, H, V,     1'b1, 1'b1, VV, 1};
        rows[6]  = '{-1, 1'b1, H, V + 1, 1'b0, 1'b1, VV, 1};
        rows[7]  = '{-1, 1'b1, H, V,     1'b0, 1'b1, VV, 1};
        rows[8]  = '{-1, 1'b0, H, V - 1, 1'b0, 1'b1, VV, 1};
        rows[9]  = '{-1, 1'b0, H, V,     1'b0, 1'b1, VV, 1};
        rows[10] = '{-1, 1'b0, H, V,     1'b1, 1'b1, VV, 1};

        hsync_n = 1'b1; vsync_n = 1'b1; blank_n = 1'b0;
        rst_ni = 1'b1;
        #3 rst_ni = 1'b0;
        repeat (3) drive_raw(1'b1, 1'b1, 1'b0);
        check_all_zero("reset");
        rst_ni = 1'b1;
        startup();

        for (int r = 0; r < 11; r++) begin
            eol_cnt = 0;
            sof_cnt = 0;
            drive_frame(rows[r].short_line, rows[r].align);
            check($sformatf("row%0d_htot", r), int'(h_total), rows[r].h_total);
            check($sformatf("row%0d_vtot", r), int'(v_total), rows[r].v_total);
            check($sformatf("row%0d_locked", r), int'(locked), int'(rows[r].locked));
            check($sformatf("row%0d_error", r), int'(error), int'(rows[r].error));
            check($sformatf("row%0d_eols", r), eol_cnt, rows[r].eols);
            check($sformatf("row%0d_sofs", r), sof_cnt, rows[r].sofs);
        end

        // Short line while locked: lock drops exactly 2 cycles after the hsync edge ending it
        for (int ln = 0; ln < 6; ln++) drive_line(ln, (ln == 5) ? H - 1 : H, 1'b0);
        for (int c = 0; c <= HS0; c++) drive_cycle(6, c, 1'b0);
        drive_cycle(6, HS0 + 1, 1'b0);
        check("short_locked_edge1", int'(locked), 1);
        drive_cycle(6, HS0 + 2, 1'b0);
        check("short_locked_edge2", int'(locked), 0);
        check("short_error", int'(error), 1);
        check("short_htot", int'(h_total), H - 1);
        for (int c = HS0 + 3; c < H; c++) drive_cycle(6, c, 1'b0);
        for (int ln = 7; ln < V; ln++) drive_line(ln, H, 1'b0);
        drive_frame(-1, 1'b0);
        check("relock_first", int'(locked), 0);
        drive_frame(-1, 1'b0);
        check("relock_second", int'(locked), 1);
        check("relock_error", int'(error), 1);

        // hsync stuck high while locked: h_cnt saturates and lock is lost
        for (int ln = 0; ln < 16; ln++) drive_line(ln, H, 1'b0);
        for (int c = 0; c <= HS0; c++) drive_cycle(16, c, 1'b0);
        first_drop = -1;
        for (int i = 1; i <= 2100; i++) begin
            if (HS0 + i < H) drive_cycle(16, HS0 + i, 1'b0);
            else drive_raw(1'b1, 1'b1, 1'b0);
            if (first_drop < 0 && !locked) first_drop = i;
        end
        check("sync_lost_cycle", first_drop, 2050);
        check("sync_lost_htot", int'(h_total), H);
        check("sync_lost_error", int'(error), 1);

        // Asynchronous reset in the middle of a frame
        drive_line(17, H, 1'b0);
        drive_line(18, H, 1'b0);
        for (int c = 0; c < 10; c++) drive_cycle(19, c, 1'b0);
        #2 rst_ni = 1'b0;
        q.delete();
        #1 check_all_zero("mid_reset");
        repeat (3) drive_raw(1'b1, 1'b1, 1'b0);
        rst_ni = 1'b1;
        startup();
        drive_frame(-1, 1'b0);
        check("post_reset_vtot", int'(v_total), V);
        check("post_reset_lock1", int'(locked), 0);
        drive_frame(-1, 1'b0);
        check("post_reset_lock2", int'(locked), 1);
        check("post_reset_error", int'(error), 0);
        check("pix_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
